// File: rtl/pipe_ctrl_pipeline.sv
// Control-bit pipeline (Decode -> Execute -> Memory slices -> Writeback) with
// ARM condition evaluation and flags register. Optional counters: PIPE_CTRL_PERF_EN.
module pipe_ctrl_pipeline #(
    parameter int ACW        = 3,
    parameter int MEM_STAGES = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           StallE,
    input  logic           FlushE,
    input  logic [3:0]     CondD,
    input  logic           PCSrcD,
    input  logic           RegWriteD,
    input  logic           MemWriteD,
    input  logic           MemtoRegD,
    input  logic           BranchD,
    input  logic           NoWriteD,
    input  logic [1:0]     FlagWriteD,
    input  logic           ALUSrcD,
    input  logic [ACW-1:0] ALUControlD,
    input  logic [3:0]     ALUFlagsE,
    output logic           ALUSrcE,
    output logic [ACW-1:0] ALUControlE,
    output logic           MemtoRegE,
    output logic           CondExE,
    output logic           BranchTakenE,
    output logic           RegWriteM,
    output logic           MemWriteM,
    output logic           MemtoRegM,
    output logic           PCSrcW,
    output logic           RegWriteW,
    output logic           MemtoRegW,
    output logic [3:0]     FlagsQ,
    output logic           PCWrPendingF
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [15:0]    SquashCnt,
    output logic [15:0]    BranchCnt
`endif
);

    typedef struct packed {
        logic [3:0]     cond;
        logic           pcsrc;
        logic           regwrite;
        logic           memwrite;
        logic           memtoreg;
        logic           branch;
        logic           nowrite;
        logic [1:0]     flagwrite;
        logic           alusrc;
        logic [ACW-1:0] aluctl;
    } ex_t;

    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memwrite;
        logic memtoreg;
    } mem_t;

    typedef struct packed {
        logic pcsrc;
        logic regwrite;
        logic memtoreg;
    } wb_t;

    ex_t        ex_q, ex_d;
    mem_t       mem_q [MEM_STAGES];
    mem_t       mem_first_d;
    wb_t        wb_q;
    logic [3:0] flags_q, flags_d;
    logic       cond_ok;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0:    cond_pass = z;
            4'd1:    cond_pass = !z;
            4'd2:    cond_pass = cf;
            4'd3:    cond_pass = !cf;
            4'd4:    cond_pass = n;
            4'd5:    cond_pass = !n;
            4'd6:    cond_pass = v;
            4'd7:    cond_pass = !v;
            4'd8:    cond_pass = cf & !z;
            4'd9:    cond_pass = !cf | z;
            4'd10:   cond_pass = (n == v);
            4'd11:   cond_pass = (n != v);
            4'd12:   cond_pass = !z & (n == v);
            4'd13:   cond_pass = z | (n != v);
            4'd14:   cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Decode -> Execute: flush beats stall, stall holds
    always_comb begin
        ex_d = ex_q;
        if (FlushE) begin
            ex_d = '0;
        end else if (!StallE) begin
            ex_d.cond      = CondD;
            ex_d.pcsrc     = PCSrcD;
            ex_d.regwrite  = RegWriteD;
            ex_d.memwrite  = MemWriteD;
            ex_d.memtoreg  = MemtoRegD;
            ex_d.branch    = BranchD;
            ex_d.nowrite   = NoWriteD;
            ex_d.flagwrite = FlagWriteD;
            ex_d.alusrc    = ALUSrcD;
            ex_d.aluctl    = ALUControlD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ex_q <= '0;
        else       ex_q <= ex_d;
    end

    assign cond_ok = cond_pass(ex_q.cond, flags_q);

    // Flags written on the edge that retires the Execute instruction
    always_comb begin
        flags_d = flags_q;
        if (cond_ok && !StallE) begin
            if (ex_q.flagwrite[1]) flags_d[3:2] = ALUFlagsE[3:2];
            if (ex_q.flagwrite[0]) flags_d[1:0] = ALUFlagsE[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) flags_q <= '0;
        else       flags_q <= flags_d;
    end

    // Execute -> Memory: condition-qualified; a stalled Execute sends a bubble
    always_comb begin
        mem_first_d = '0;
        if (!StallE) begin
            mem_first_d.pcsrc    = ex_q.pcsrc & cond_ok;
            mem_first_d.regwrite = ex_q.regwrite & cond_ok & !ex_q.nowrite;
            mem_first_d.memwrite = ex_q.memwrite & cond_ok;
            mem_first_d.memtoreg = ex_q.memtoreg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < MEM_STAGES; k++) mem_q[k] <= '0;
        end else begin
            mem_q[0] <= mem_first_d;
            for (int k = 1; k < MEM_STAGES; k++) mem_q[k] <= mem_q[k-1];
        end
    end

    // Memory -> Writeback: memory write is consumed before Writeback
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q <= '0;
        end else begin
            wb_q.pcsrc    <= mem_q[MEM_STAGES-1].pcsrc;
            wb_q.regwrite <= mem_q[MEM_STAGES-1].regwrite;
            wb_q.memtoreg <= mem_q[MEM_STAGES-1].memtoreg;
        end
    end

    always_comb begin
        PCWrPendingF = PCSrcD | ex_q.pcsrc;
        for (int k = 0; k < MEM_STAGES; k++) PCWrPendingF = PCWrPendingF | mem_q[k].pcsrc;
    end

    assign ALUSrcE      = ex_q.alusrc;
    assign ALUControlE  = ex_q.aluctl;
    assign MemtoRegE    = ex_q.memtoreg;
    assign CondExE      = cond_ok;
    assign BranchTakenE = ex_q.branch & cond_ok;
    assign RegWriteM    = mem_q[0].regwrite;
    assign MemWriteM    = mem_q[0].memwrite;
    assign MemtoRegM    = mem_q[0].memtoreg;
    assign PCSrcW       = wb_q.pcsrc;
    assign RegWriteW    = wb_q.regwrite;
    assign MemtoRegW    = wb_q.memtoreg;
    assign FlagsQ       = flags_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] squash_cnt_q, squash_cnt_d;
    logic [15:0] branch_cnt_q, branch_cnt_d;
    logic        squash_ev;

    function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic inc);
        if (inc && c != 16'hFFFF) sat_inc = c + 16'd1;
        else                      sat_inc = c;
    endfunction

    assign squash_ev    = !StallE && !cond_ok && (ex_q.regwrite | ex_q.memwrite | ex_q.pcsrc);
    assign squash_cnt_d = sat_inc(squash_cnt_q, squash_ev);
    assign branch_cnt_d = sat_inc(branch_cnt_q, BranchTakenE & !StallE);

    always_ff @(posedge clk) begin
        if (reset) begin
            squash_cnt_q <= '0;
            branch_cnt_q <= '0;
        end else begin
            squash_cnt_q <= squash_cnt_d;
            branch_cnt_q <= branch_cnt_d;
        end
    end

    assign SquashCnt = squash_cnt_q;
    assign BranchCnt = branch_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl_pipeline.sv
// Randomized bench for pipe_ctrl_pipeline against an instruction-level queue model.
module tb_pipe_ctrl_pipeline;
    localparam int ACW = 3;
    localparam int MS  = 3;

    logic           clk = 1'b0;
    logic           reset, StallE, FlushE;
    logic [3:0]     CondD;
    logic           PCSrcD, RegWriteD, MemWriteD, MemtoRegD, BranchD, NoWriteD, ALUSrcD;
    logic [1:0]     FlagWriteD;
    logic [ACW-1:0] ALUControlD;
    logic [3:0]     ALUFlagsE;
    logic           ALUSrcE, MemtoRegE, CondExE, BranchTakenE;
    logic [ACW-1:0] ALUControlE;
    logic           RegWriteM, MemWriteM, MemtoRegM, PCSrcW, RegWriteW, MemtoRegW;
    logic [3:0]     FlagsQ;
    logic           PCWrPendingF;
`ifdef PIPE_CTRL_PERF_EN
    logic [15:0]    SquashCnt, BranchCnt;
`endif

    always #5 clk = ~clk;

    pipe_ctrl_pipeline #(.ACW(ACW), .MEM_STAGES(MS)) dut (
        .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
        .CondD(CondD), .PCSrcD(PCSrcD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
        .MemtoRegD(MemtoRegD), .BranchD(BranchD), .NoWriteD(NoWriteD),
        .FlagWriteD(FlagWriteD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .ALUFlagsE(ALUFlagsE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .MemtoRegE(MemtoRegE), .CondExE(CondExE), .BranchTakenE(BranchTakenE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
        .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .FlagsQ(FlagsQ), .PCWrPendingF(PCWrPendingF)
`ifdef PIPE_CTRL_PERF_EN
        , .SquashCnt(SquashCnt), .BranchCnt(BranchCnt)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction-level reference model
    typedef struct packed {
        bit [3:0]     cond;
        bit           pc, rw, mw, m2r, br, nw;
        bit [1:0]     fw;
        bit           alusrc;
        bit [ACW-1:0] aluc;
    } instr_t;

    typedef struct packed { bit pc, rw, mw, m2r; } slot_t;

    instr_t m_e;
    bit [3:0] m_flags;
    slot_t m_mem[$];
    slot_t m_w;
    int m_sq, m_bc;

    // Pairs of conditions are complements; the odd member of each pair inverts
    function automatic bit cond_ok(input bit [3:0] c, input bit [3:0] f);
        bit n, z, cf, v, r;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cf;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cf && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return c[0] ? !r : r;
    endfunction

    task automatic model_clock();
        bit cp;
        slot_t first;
        if (reset) begin
            m_e = '0; m_flags = '0; m_w = '0; m_sq = 0; m_bc = 0;
            m_mem.delete();
            for (int k = 0; k < MS; k++) m_mem.push_back('0);
        end else begin
            cp = cond_ok(m_e.cond, m_flags);
            m_w = m_mem[MS-1];
            first = '0;
            if (!StallE) begin
                first.pc  = m_e.pc && cp;
                first.rw  = m_e.rw && cp && !m_e.nw;
                first.mw  = m_e.mw && cp;
                first.m2r = m_e.m2r;
                if (cp && m_e.fw[1]) m_flags[3:2] = ALUFlagsE[3:2];
                if (cp && m_e.fw[0]) m_flags[1:0] = ALUFlagsE[1:0];
                if (!cp && (m_e.rw || m_e.mw || m_e.pc) && m_sq < 65535) m_sq++;
                if (cp && m_e.br && m_bc < 65535) m_bc++;
            end
            m_mem.push_front(first);
            void'(m_mem.pop_back());
            if (FlushE) m_e = '0;
            else if (!StallE) begin
                m_e.cond = CondD; m_e.pc = PCSrcD; m_e.rw = RegWriteD; m_e.mw = MemWriteD;
                m_e.m2r = MemtoRegD; m_e.br = BranchD; m_e.nw = NoWriteD; m_e.fw = FlagWriteD;
                m_e.alusrc = ALUSrcD; m_e.aluc = ALUControlD;
            end
        end
    endtask

    task automatic check_outputs(input string pfx);
        bit cp, pend;
        cp = cond_ok(m_e.cond, m_flags);
        pend = PCSrcD || m_e.pc;
        foreach (m_mem[k]) pend = pend || m_mem[k].pc;
        check_val({pfx, "_e"}, {ALUSrcE, ALUControlE, MemtoRegE},
                  {m_e.alusrc, m_e.aluc, m_e.m2r});
        check_val({pfx, "_cond"}, {CondExE, BranchTakenE}, {cp, cp && m_e.br});
        check_val({pfx, "_mem"}, {RegWriteM, MemWriteM, MemtoRegM},
                  {m_mem[0].rw, m_mem[0].mw, m_mem[0].m2r});
        check_val({pfx, "_wb"}, {PCSrcW, RegWriteW, MemtoRegW}, {m_w.pc, m_w.rw, m_w.m2r});
        check_val({pfx, "_flags"}, FlagsQ, m_flags);
        check_val({pfx, "_pend"}, PCWrPendingF, pend);
`ifdef PIPE_CTRL_PERF_EN
        check_val({pfx, "_sqcnt"}, SquashCnt, m_sq);
        check_val({pfx, "_brcnt"}, BranchCnt, m_bc);
`endif
    endtask

    task automatic step(input string pfx);
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_outputs(pfx);
    endtask

    task automatic clear_inputs();
        StallE = 0; FlushE = 0; CondD = 4'd14; PCSrcD = 0; RegWriteD = 0; MemWriteD = 0;
        MemtoRegD = 0; BranchD = 0; NoWriteD = 0; FlagWriteD = 0; ALUSrcD = 0;
        ALUControlD = '0; ALUFlagsE = '0;
    endtask

    int lat;

    initial begin
        clear_inputs();
        reset = 1;
        step("rst");
        step("rst");

        // Single AL register write: Writeback latency is MS+2 edges
        reset = 0;
        RegWriteD = 1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            step("lat");
            RegWriteD = 0;
            if (RegWriteW === 1'b1 && lat == 0) lat = k;
        end
        check_val("lat_regwrite_w", lat, MS + 2);

        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(99) < 2);
            StallE      = ($urandom_range(99) < 20);
            FlushE      = ($urandom_range(99) < 10);
            CondD       = ($urandom_range(1) == 0) ? 4'd14 : 4'($urandom_range(15));
            PCSrcD      = ($urandom_range(99) < 20);
            RegWriteD   = $urandom_range(1);
            MemWriteD   = $urandom_range(1);
            MemtoRegD   = $urandom_range(1);
            BranchD     = ($urandom_range(99) < 30);
            NoWriteD    = ($urandom_range(99) < 25);
            FlagWriteD  = 2'($urandom_range(3));
            ALUSrcD     = $urandom_range(1);
            ALUControlD = ACW'($urandom);
            ALUFlagsE   = 4'($urandom_range(15));
            step("rnd");
        end

        // Reset from a busy pipeline clears everything in one edge
        clear_inputs();
        reset = 1;
        step("rst_end");
        check_val("rst_end_all", {ALUSrcE, MemtoRegE, RegWriteM, MemWriteM, MemtoRegM,
                                  PCSrcW, RegWriteW, MemtoRegW, FlagsQ, PCWrPendingF}, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
